lsu_ctrl: RTL and testbench

LSU_CTRL -- requirements
Module: lsu_ctrl

---
 rtl/lsu_pkg.sv | 38 +++
 rtl/lsu_addr_chk.sv | 24 ++
 rtl/lsu_ctrl.sv | 142 ++++++++++++++
 tb/tb_lsu_ctrl.sv | 304 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/lsu_pkg.sv
// rtl/lsu_pkg.sv - op/state encodings, default address width and op decode helpers for the load/store unit
package lsu_pkg;

   localparam int DM_AW_DEF = 12;

   typedef enum logic [2:0] {
      OP_LW  = 3'b000,
      OP_LB  = 3'b001,
      OP_LBU = 3'b010,
      OP_SW  = 3'b011,
      OP_SB  = 3'b100
   } lsu_op_e;

   typedef enum logic [2:0] {
      ST_IDLE  = 3'd0,
      ST_ISSUE = 3'd1,
      ST_WAIT  = 3'd2,
      ST_RESP  = 3'd3,
      ST_ERR   = 3'd4
   } lsu_state_e;

   function automatic logic op_is_load(input logic [2:0] op);
      return (op == OP_LW) || (op == OP_LB) || (op == OP_LBU);
   endfunction

   function automatic logic op_is_store(input logic [2:0] op);
      return (op == OP_SW) || (op == OP_SB);
   endfunction

   function automatic logic op_is_word(input logic [2:0] op);
      return (op == OP_LW) || (op == OP_SW);
   endfunction

   function automatic logic op_is_byte(input logic [2:0] op);
      return (op == OP_LB) || (op == OP_LBU) || (op == OP_SB);
   endfunction

endpackage

// File: rtl/lsu_addr_chk.sv
// rtl/lsu_addr_chk.sv - combinational legality check of a request's op and address
module lsu_addr_chk
   import lsu_pkg::*;
#(
   parameter int DM_AW = DM_AW_DEF
)
(
   input  logic [2:0]  op,
   input  logic [31:0] addr,
   output logic        legal
);

   logic [31:0] w_hi;
   logic        w_op_ok;
   logic        w_in_range;
   logic        w_aligned;

   assign w_hi       = addr >> DM_AW;
   assign w_op_ok    = op_is_load(op) || op_is_store(op);
   assign w_in_range = (w_hi == 32'd0);
   assign w_aligned  = !op_is_word(op) || (addr[1:0] == 2'b00);
   assign legal      = w_op_ok && w_in_range && w_aligned;

endmodule

// File: rtl/lsu_ctrl.sv
// rtl/lsu_ctrl.sv - load/store sequencer between the pipeline and a registered-output data memory
module lsu_ctrl
   import lsu_pkg::*;
#(
   parameter int DM_AW = DM_AW_DEF
)
(
   input  logic             clk,
   input  logic             rst_n,
   input  logic             req_valid,
   output logic             req_ready,
   input  logic [2:0]       req_op,
   input  logic [31:0]      req_addr,
   input  logic [31:0]      req_wdata,
   input  logic [4:0]       req_rd,
   input  logic             flush,
   output logic             resp_valid,
   output logic [31:0]      resp_data,
   output logic [4:0]       resp_rd,
   output logic             addr_err,
   output logic [31:0]      err_addr,
   output logic             busy,
   output logic [DM_AW-1:0] dm_addr,
   output logic             dm_bitop,
   output logic             dm_extop,
   output logic             dm_we,
   output logic             dm_memread,
   output logic [31:0]      dm_din,
   input  logic [31:0]      dm_dout
);

   lsu_state_e       r_state;
   lsu_state_e       w_next;
   logic [2:0]       r_op;
   logic [DM_AW-1:0] r_addr;
   logic [31:0]      r_wdata;
   logic [4:0]       r_rd;
   logic [31:0]      r_resp_data;
   logic [31:0]      r_err_addr;
   logic             w_legal;
   logic             w_accept;
   logic             w_active;

   lsu_addr_chk #(.DM_AW(DM_AW)) u_addr_chk (
      .op    (req_op),
      .addr  (req_addr),
      .legal (w_legal)
   );

   assign w_accept = req_valid && (r_state == ST_IDLE);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state <= ST_IDLE;
      end else begin
         r_state <= w_next;
      end
   end

   // Strobes decode straight from state so an async reset drops them immediately.
   always_comb begin
      w_next     = r_state;
      req_ready  = 1'b0;
      resp_valid = 1'b0;
      addr_err   = 1'b0;
      dm_we      = 1'b0;
      dm_memread = 1'b0;
      dm_bitop   = 1'b0;
      dm_extop   = 1'b0;
      dm_addr    = '0;
      w_active   = (r_state == ST_ISSUE) || (r_state == ST_WAIT);

      case (r_state)
         ST_IDLE: begin
            req_ready = 1'b1;
            if (req_valid) begin
               w_next = w_legal ? ST_ISSUE : ST_ERR;
            end
         end
         ST_ISSUE: begin
            if (op_is_store(r_op) || flush) begin
               w_next = ST_IDLE;
            end else begin
               w_next = ST_WAIT;
            end
         end
         ST_WAIT:  w_next = flush ? ST_IDLE : ST_RESP;
         ST_RESP:  w_next = ST_IDLE;
         ST_ERR:   w_next = ST_IDLE;
         default:  w_next = ST_IDLE;
      endcase

      if (r_state == ST_RESP) begin
         resp_valid = 1'b1;
      end
      if (r_state == ST_ERR) begin
         addr_err = 1'b1;
      end
      if (w_active) begin
         dm_we      = (r_state == ST_ISSUE) && op_is_store(r_op);
         dm_memread = op_is_load(r_op);
         dm_bitop   = op_is_byte(r_op);
         dm_extop   = (r_op == OP_LB);
         dm_addr    = r_addr;
         if (op_is_word(r_op)) begin
            dm_addr[1:0] = 2'b00;
         end
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_op        <= 3'b000;
         r_addr      <= '0;
         r_wdata     <= 32'd0;
         r_rd        <= 5'd0;
         r_resp_data <= 32'd0;
         r_err_addr  <= 32'd0;
      end else begin
         if (w_accept) begin
            r_op    <= req_op;
            r_addr  <= req_addr[DM_AW-1:0];
            r_wdata <= req_wdata;
            r_rd    <= req_rd;
            if (!w_legal) begin
               r_err_addr <= req_addr;
            end
         end
         // A flushed load never reaches RESP, so its data must not overwrite the last result.
         if ((r_state == ST_WAIT) && !flush) begin
            r_resp_data <= dm_dout;
         end
      end
   end

   assign busy      = ~req_ready;
   assign resp_data = r_resp_data;
   assign resp_rd   = r_rd;
   assign err_addr  = r_err_addr;
   assign dm_din    = r_wdata;

endmodule

// File: tb/tb_lsu_ctrl.sv
// tb/tb_lsu_ctrl.sv - directed table-driven bench for lsu_ctrl with hand sequences for flush and reset
module tb_lsu_ctrl;

   localparam int K_ST = 0;
   localparam int K_LD = 1;
   localparam int K_ER = 2;

   logic        clk;
   logic        rst_n;
   logic        req_valid;
   logic        req_ready;
   logic [2:0]  req_op;
   logic [31:0] req_addr;
   logic [31:0] req_wdata;
   logic [4:0]  req_rd;
   logic        flush;
   logic        resp_valid;
   logic [31:0] resp_data;
   logic [4:0]  resp_rd;
   logic        addr_err;
   logic [31:0] err_addr;
   logic        busy;
   logic [11:0] dm_addr;
   logic        dm_bitop;
   logic        dm_extop;
   logic        dm_we;
   logic        dm_memread;
   logic [31:0] dm_din;
   logic [31:0] dm_dout;

   int n_cmp = 0;
   int n_err = 0;
   logic [31:0] last_data;
   logic [31:0] last_err;

   typedef struct {
      logic [2:0]  op;
      logic [31:0] addr;
      logic [31:0] wdata;
      logic [4:0]  rd;
      logic [31:0] dout;
      int          kind;
      logic [11:0] e_addr;
      logic        e_bitop;
      logic        e_extop;
   } vec_t;

   vec_t vecs[11];

   lsu_ctrl #(.DM_AW(12)) dut (
      .clk        (clk),
      .rst_n      (rst_n),
      .req_valid  (req_valid),
      .req_ready  (req_ready),
      .req_op     (req_op),
      .req_addr   (req_addr),
      .req_wdata  (req_wdata),
      .req_rd     (req_rd),
      .flush      (flush),
      .resp_valid (resp_valid),
      .resp_data  (resp_data),
      .resp_rd    (resp_rd),
      .addr_err   (addr_err),
      .err_addr   (err_addr),
      .busy       (busy),
      .dm_addr    (dm_addr),
      .dm_bitop   (dm_bitop),
      .dm_extop   (dm_extop),
      .dm_we      (dm_we),
      .dm_memread (dm_memread),
      .dm_din     (dm_din),
      .dm_dout    (dm_dout)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial begin
      #500000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got 0x%08h expected 0x%08h", nm, act, exp);
      end
   endtask

   task automatic drive(input logic [2:0] op, input logic [31:0] addr,
                        input logic [31:0] wdata, input logic [4:0] rd);
      req_valid = 1'b1;
      req_op    = op;
      req_addr  = addr;
      req_wdata = wdata;
      req_rd    = rd;
   endtask

   task automatic idle_inputs();
      req_valid = 1'b0;
      req_op    = 3'b111;
      req_addr  = 32'hFFFF_FFFF;
      req_wdata = 32'h0F0F_0F0F;
      req_rd    = 5'd30;
   endtask

   // Called at a negedge in an IDLE cycle; returns at the negedge of the following IDLE cycle.
   task automatic apply(input vec_t v, input string tg);
      chk({tg, ".ready"}, req_ready, 1);
      chk({tg, ".busy"}, busy, 0);
      drive(v.op, v.addr, v.wdata, v.rd);
      @(negedge clk);
      idle_inputs();
      if (v.kind == K_ER) begin
         chk({tg, ".addr_err"}, addr_err, 1);
         chk({tg, ".err_addr"}, err_addr, v.addr);
         chk({tg, ".we"}, dm_we, 0);
         chk({tg, ".memread"}, dm_memread, 0);
         chk({tg, ".busy_err"}, busy, 1);
         @(negedge clk);
         chk({tg, ".addr_err_drop"}, addr_err, 0);
         chk({tg, ".err_hold"}, err_addr, v.addr);
         last_err = v.addr;
      end else if (v.kind == K_ST) begin
         chk({tg, ".we"}, dm_we, 1);
         chk({tg, ".memread"}, dm_memread, 0);
         chk({tg, ".dm_addr"}, dm_addr, v.e_addr);
         chk({tg, ".dm_din"}, dm_din, v.wdata);
         chk({tg, ".bitop"}, dm_bitop, v.e_bitop);
         chk({tg, ".resp_valid"}, resp_valid, 0);
         @(negedge clk);
         chk({tg, ".we_drop"}, dm_we, 0);
         chk({tg, ".resp_valid2"}, resp_valid, 0);
      end else begin
         chk({tg, ".memread_issue"}, dm_memread, 1);
         chk({tg, ".we"}, dm_we, 0);
         chk({tg, ".dm_addr"}, dm_addr, v.e_addr);
         chk({tg, ".bitop"}, dm_bitop, v.e_bitop);
         chk({tg, ".extop"}, dm_extop, v.e_extop);
         chk({tg, ".resp_early"}, resp_valid, 0);
         dm_dout = 32'h5555_5555;
         @(negedge clk);
         chk({tg, ".memread_wait"}, dm_memread, 1);
         chk({tg, ".dm_addr_wait"}, dm_addr, v.e_addr);
         chk({tg, ".bitop_wait"}, dm_bitop, v.e_bitop);
         chk({tg, ".extop_wait"}, dm_extop, v.e_extop);
         chk({tg, ".resp_wait"}, resp_valid, 0);
         dm_dout = v.dout;
         @(negedge clk);
         dm_dout = ~v.dout;
         chk({tg, ".resp_valid"}, resp_valid, 1);
         chk({tg, ".resp_data"}, resp_data, v.dout);
         chk({tg, ".resp_rd"}, resp_rd, v.rd);
         chk({tg, ".memread_resp"}, dm_memread, 0);
         @(negedge clk);
         chk({tg, ".resp_drop"}, resp_valid, 0);
         chk({tg, ".resp_hold"}, resp_data, v.dout);
         last_data = v.dout;
      end
   endtask

   initial begin
      vecs[0]  = '{3'b011, 32'h0000_0010, 32'hDEAD_BEEF, 5'd0,  32'h0,         K_ST, 12'h010, 1'b0, 1'b0};
      vecs[1]  = '{3'b001, 32'h0000_0013, 32'h0,         5'd5,  32'h80FF_FFFF, K_LD, 12'h013, 1'b1, 1'b1};
      vecs[2]  = '{3'b000, 32'h0000_0006, 32'h0,         5'd3,  32'h0,         K_ER, 12'h000, 1'b0, 1'b0};
      vecs[3]  = '{3'b010, 32'h0000_1000, 32'h0,         5'd4,  32'h0,         K_ER, 12'h000, 1'b0, 1'b0};
      vecs[4]  = '{3'b000, 32'h0000_0024, 32'h0,         5'd31, 32'h1234_5678, K_LD, 12'h024, 1'b0, 1'b0};
      vecs[5]  = '{3'b010, 32'h0000_0FFF, 32'h0,         5'd1,  32'h0000_00AB, K_LD, 12'hFFF, 1'b1, 1'b0};
      vecs[6]  = '{3'b100, 32'h0000_0007, 32'hCAFE_BA5E, 5'd0,  32'h0,         K_ST, 12'h007, 1'b1, 1'b0};
      vecs[7]  = '{3'b101, 32'h0000_0020, 32'h0,         5'd2,  32'h0,         K_ER, 12'h000, 1'b0, 1'b0};
      vecs[8]  = '{3'b011, 32'h0000_0002, 32'h1,         5'd0,  32'h0,         K_ER, 12'h000, 1'b0, 1'b0};
      vecs[9]  = '{3'b011, 32'h8000_0000, 32'h2,         5'd0,  32'h0,         K_ER, 12'h000, 1'b0, 1'b0};
      vecs[10] = '{3'b000, 32'h0000_0FFC, 32'h0,         5'd0,  32'hA5A5_A5A5, K_LD, 12'hFFC, 1'b0, 1'b0};

      rst_n   = 1'b0;
      flush   = 1'b0;
      dm_dout = 32'h0;
      last_data = 32'h0;
      last_err  = 32'h0;
      idle_inputs();
      repeat (2) @(negedge clk);
      chk("rst.resp_valid", resp_valid, 0);
      chk("rst.addr_err", addr_err, 0);
      chk("rst.we", dm_we, 0);
      chk("rst.memread", dm_memread, 0);
      chk("rst.resp_data", resp_data, 0);
      chk("rst.resp_rd", resp_rd, 0);
      chk("rst.err_addr", err_addr, 0);
      chk("rst.dm_addr", dm_addr, 0);
      chk("rst.dm_din", dm_din, 0);
      rst_n = 1'b1;
      @(negedge clk);
      chk("rst.ready", req_ready, 1);
      chk("rst.busy", busy, 0);

      for (int i = 0; i < 11; i++) begin
         apply(vecs[i], $sformatf("v%0d", i));
      end

      // flush in WAIT, then a byte store in the very next cycle
      drive(3'b000, 32'h40, 32'h0, 5'd7);
      @(negedge clk);
      idle_inputs();
      chk("fw.memread_issue", dm_memread, 1);
      @(negedge clk);
      flush = 1'b1;
      dm_dout = 32'h0BAD_0BAD;
      chk("fw.memread_wait", dm_memread, 1);
      @(negedge clk);
      flush = 1'b0;
      chk("fw.ready", req_ready, 1);
      chk("fw.memread_drop", dm_memread, 0);
      chk("fw.no_resp", resp_valid, 0);
      chk("fw.data_hold", resp_data, last_data);
      drive(3'b100, 32'h5, 32'h0000_00C3, 5'd0);
      @(negedge clk);
      idle_inputs();
      chk("fw.sb_we", dm_we, 1);
      chk("fw.sb_addr", dm_addr, 12'h005);
      chk("fw.sb_din", dm_din, 32'h0000_00C3);
      chk("fw.sb_no_resp", resp_valid, 0);
      @(negedge clk);
      chk("fw.sb_we_drop", dm_we, 0);
      chk("fw.sb_no_resp2", resp_valid, 0);

      // flush in ISSUE of a load
      drive(3'b010, 32'h30, 32'h0, 5'd8);
      @(negedge clk);
      idle_inputs();
      flush = 1'b1;
      chk("fi.memread", dm_memread, 1);
      @(negedge clk);
      flush = 1'b0;
      chk("fi.ready", req_ready, 1);
      chk("fi.memread_drop", dm_memread, 0);
      @(negedge clk);
      chk("fi.no_resp", resp_valid, 0);

      // flush cannot cancel a store in ISSUE
      drive(3'b011, 32'h44, 32'h0000_0001, 5'd0);
      @(negedge clk);
      idle_inputs();
      flush = 1'b1;
      chk("fs.we", dm_we, 1);
      @(negedge clk);
      flush = 1'b0;
      chk("fs.we_drop", dm_we, 0);
      chk("fs.ready", req_ready, 1);

      // flush in IDLE has no effect on acceptance
      flush = 1'b1;
      drive(3'b011, 32'h48, 32'h0000_0002, 5'd0);
      @(negedge clk);
      idle_inputs();
      flush = 1'b0;
      chk("fidle.we", dm_we, 1);
      chk("fidle.addr", dm_addr, 12'h048);
      @(negedge clk);

      // flush during RESP does not suppress the pulse
      drive(3'b000, 32'h4C, 32'h0, 5'd9);
      @(negedge clk);
      idle_inputs();
      @(negedge clk);
      dm_dout = 32'h0000_0077;
      @(negedge clk);
      flush = 1'b1;
      chk("fr.resp_valid", resp_valid, 1);
      chk("fr.resp_data", resp_data, 32'h0000_0077);
      chk("fr.resp_rd", resp_rd, 5'd9);
      @(negedge clk);
      flush = 1'b0;
      chk("fr.resp_drop", resp_valid, 0);
      chk("fr.ready", req_ready, 1);

      // reset during WAIT
      drive(3'b000, 32'h50, 32'h0, 5'd11);
      @(negedge clk);
      idle_inputs();
      @(negedge clk);
      dm_dout = 32'h1111_2222;
      chk("rw.memread_wait", dm_memread, 1);
      rst_n = 1'b0;
      #1;
      chk("rw.memread_async", dm_memread, 0);
      chk("rw.dm_addr_async", dm_addr, 0);
      chk("rw.resp_data_async", resp_data, 0);
      chk("rw.err_addr_async", err_addr, 0);
      #2;
      rst_n = 1'b1;
      for (int k = 0; k < 3; k++) begin
         @(negedge clk);
         chk($sformatf("rw.no_resp%0d", k), resp_valid, 0);
         chk($sformatf("rw.ready%0d", k), req_ready, 1);
         chk($sformatf("rw.no_we%0d", k), dm_we, 0);
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
